uart_tx_nch: RTL and testbench

Parametrised multi-channel UART transmitter: serialises one character per `tx_start` request at one of `ch_num` compile-time baud rates, chosen per frame by `ch_sel`. It generalises the two-rate switchable transmitter to:
- N rates;
- configurable data width;
- optional even/odd parity;
- 1 or 2 stop bits;
- frame-atomic configuration, latched at the start of each frame.

It sits between the command/response formatter and the board UART pin.

---
 rtl/uart_tx_nch_if.sv | 25 ++
 rtl/uart_tx_nch.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_nch.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_nch_if.sv
// uart_tx_nch request/line bundle.
// Master drives requests, slave is the transmitter.
interface uart_tx_nch_if #(
    parameter int DW = 8,
    parameter int SW = 2
);
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic [SW-1:0] ch_sel;
    logic [1:0]    parity_mode;
    logic          stop2;
    logic          tx;
    logic          tx_idle;
    logic          tx_done;

    modport master (
        output tx_start, tx_data, ch_sel, parity_mode, stop2,
        input  tx, tx_idle, tx_done
    );

    modport slave (
        input  tx_start, tx_data, ch_sel, parity_mode, stop2,
        output tx, tx_idle, tx_done
    );
endinterface

// File: rtl/uart_tx_nch.sv
// uart_tx_nch: multi-rate UART transmitter.
// Frame config is latched on acceptance.
module uart_tx_nch #(
    parameter int unsigned clock_freq = 100_000_000,
    parameter int unsigned ch_num = 4,
    parameter logic [32*ch_num-1:0] ch_rates =
        {32'd9600, 32'd19200, 32'd57600, 32'd115200},
    parameter int unsigned data_bits = 8
) (
    input logic         clk,
    input logic         rst,
    uart_tx_nch_if.slave bus
);
    localparam int SEL_W = (ch_num > 1) ? $clog2(ch_num) : 1;
    localparam int TAB_N = 1 << SEL_W;
    localparam logic [3:0] LAST_BIT = 4'(data_bits - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // Unused select codes alias channel 0.
    logic [31:0] div_tab [TAB_N];

    for (genvar k = 0; k < TAB_N; k++) begin : g_div
        if (k < ch_num) begin : g_on
            localparam int unsigned DIV =
                clock_freq / ch_rates[32*k +: 32];
            if (DIV < 2) begin : g_bad
                $error("uart_tx_nch: divisor below 2");
            end
            assign div_tab[k] = DIV;
        end else begin : g_off
            assign div_tab[k] = clock_freq / ch_rates[31:0];
        end
    end

    state_t               state_q, state_d;
    logic [data_bits-1:0] data_q, data_d;
    logic [31:0]          div_q, div_d;
    logic [31:0]          baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;
    logic                 idle_q, idle_d;
    logic                 done_q, done_d;
    logic                 baud_last;

    assign baud_last = (baud_q == div_q - 32'd1);

    // Next-state, latched config and registered line value.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        div_d     = div_q;
        baud_d    = baud_last ? 32'd0 : baud_q + 32'd1;
        bit_d     = bit_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        idle_d    = idle_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                baud_d = 32'd0;
                bit_d  = 4'd0;
                if (bus.tx_start) begin
                    state_d   = S_START;
                    data_d    = bus.tx_data;
                    div_d     = div_tab[bus.ch_sel];
                    par_en_d  = (bus.parity_mode == 2'b01) ||
                                (bus.parity_mode == 2'b10);
                    par_bit_d = (^bus.tx_data) ^
                                (bus.parity_mode == 2'b10);
                    stop2_d   = bus.stop2;
                    tx_d      = 1'b0;
                    idle_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_d = S_DATA;
                    bit_d   = 4'd0;
                    tx_d    = data_q[0];
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d = 4'd0;
                        if (par_en_q) begin
                            state_d = S_PAR;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        data_d = data_q >> 1;
                        tx_d   = data_q[1];
                    end
                end
            end
            S_PAR: begin
                if (baud_last) begin
                    state_d = S_STOP;
                    bit_d   = 4'd0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    if (stop2_q && bit_q == 4'd0) begin
                        bit_d = 4'd1;
                    end else begin
                        state_d = S_IDLE;
                        bit_d   = 4'd0;
                        idle_d  = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                idle_d  = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            div_q     <= 32'd0;
            baud_q    <= 32'd0;
            bit_q     <= 4'd0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            idle_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            div_q     <= div_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            idle_q    <= idle_d;
            done_q    <= done_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_idle = idle_q;
    assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_nch.sv
// tb_uart_tx_nch: directed frame checks.
// Second instance covers out-of-range ch_sel.
module tb_uart_tx_nch;
    logic clk;
    logic rst;
    logic sel3;
    logic tx_m;
    logic idle_m;
    logic done_m;
    int   n_chk;
    int   n_fail;

    uart_tx_nch_if #(.DW(8), .SW(2)) bus ();
    uart_tx_nch_if #(.DW(8), .SW(2)) bus3 ();

    uart_tx_nch #(
        .clock_freq(1_000_000),
        .ch_num(4),
        .ch_rates({32'd100000, 32'd50000, 32'd20000, 32'd10000}),
        .data_bits(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    uart_tx_nch #(
        .clock_freq(1_000_000),
        .ch_num(3),
        .ch_rates({32'd50000, 32'd20000, 32'd10000}),
        .data_bits(8)
    ) dut3 (
        .clk(clk),
        .rst(rst),
        .bus(bus3)
    );

    assign tx_m   = sel3 ? bus3.tx      : bus.tx;
    assign idle_m = sel3 ? bus3.tx_idle : bus.tx_idle;
    assign done_m = sel3 ? bus3.tx_done : bus.tx_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got,
                        input logic exp);
        chk(tag, {31'd0, got}, {31'd0, exp});
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] sel,
                        input logic [1:0] pm, input logic st2,
                        input logic hold);
        bus.tx_data     = d;
        bus.ch_sel      = sel;
        bus.parity_mode = pm;
        bus.stop2       = st2;
        bus.tx_start    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.tx_start = 1'b0;
    endtask

    // Entered 1ns after the accepting edge; exp[0] is sent first.
    task automatic chk_frame(input string nm, input logic [15:0] exp,
                             input int nb, input int dv);
        logic gotv;
        int   bad_ctl;
        bad_ctl = 0;
        for (int i = 0; i < nb; i++) begin
            gotv = exp[i];
            for (int j = 0; j < dv; j++) begin
                if (tx_m !== exp[i]) gotv = tx_m;
                if (done_m !== 1'b0 || idle_m !== 1'b0) bad_ctl++;
                @(posedge clk);
                #1;
            end
            chk1($sformatf("%s_bit%0d", nm, i), gotv, exp[i]);
        end
        chk($sformatf("%s_ctl", nm), bad_ctl, 0);
        chk1($sformatf("%s_done", nm), done_m, 1'b1);
        chk1($sformatf("%s_idle", nm), idle_m, 1'b1);
        chk1($sformatf("%s_line", nm), tx_m, 1'b1);
    endtask

    task automatic post(input string nm);
        @(posedge clk);
        #1;
        chk1($sformatf("%s_done_pulse", nm), done_m, 1'b0);
        chk1($sformatf("%s_idle_after", nm), idle_m, 1'b1);
        chk1($sformatf("%s_line_after", nm), tx_m, 1'b1);
    endtask

    task automatic quiet(input string nm, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done_m !== 1'b0 || tx_m !== 1'b1) n++;
        end
        chk($sformatf("%s_quiet", nm), n, 0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        sel3 = 1'b0;
        rst = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_data = 8'h00;
        bus.ch_sel = 2'd0;
        bus.parity_mode = 2'b00;
        bus.stop2 = 1'b0;
        bus3.tx_start = 1'b0;
        bus3.tx_data = 8'h00;
        bus3.ch_sel = 2'd0;
        bus3.parity_mode = 2'b00;
        bus3.stop2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_tx", bus.tx, 1'b1);
        chk1("rst_idle", bus.tx_idle, 1'b1);
        chk1("rst_done", bus.tx_done, 1'b0);
        chk1("rst_tx3", bus3.tx, 1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send(8'hA5, 2'd3, 2'b00, 1'b0, 1'b0);
        chk_frame("t1", {6'd0, 1'b1, 8'hA5, 1'b0}, 10, 10);
        post("t1");

        send(8'h03, 2'd2, 2'b01, 1'b0, 1'b0);
        chk_frame("t2e", {5'd0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, 20);
        post("t2e");

        send(8'h03, 2'd2, 2'b10, 1'b0, 1'b0);
        chk_frame("t2o", {5'd0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, 20);
        post("t2o");

        send(8'h3C, 2'd1, 2'b11, 1'b1, 1'b0);
        chk_frame("t3", {5'd0, 2'b11, 8'h3C, 1'b0}, 11, 50);
        post("t3");

        send(8'h55, 2'd3, 2'b00, 1'b0, 1'b1);
        fork
            chk_frame("t4a", {6'd0, 1'b1, 8'h55, 1'b0}, 10, 10);
            begin
                repeat (30) @(posedge clk);
                #2;
                bus.tx_data = 8'hAA;
                bus.ch_sel = 2'd1;
            end
        join
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
        chk_frame("t4b", {6'd0, 1'b1, 8'hAA, 1'b0}, 10, 50);
        post("t4b");

        send(8'h0F, 2'd3, 2'b00, 1'b0, 1'b0);
        fork
            chk_frame("t5", {6'd0, 1'b1, 8'h0F, 1'b0}, 10, 10);
            begin
                repeat (40) @(posedge clk);
                #2;
                bus.tx_data = 8'hFF;
                bus.tx_start = 1'b1;
                @(posedge clk);
                #2;
                bus.tx_start = 1'b0;
            end
        join
        post("t5");
        quiet("t5", 30);

        sel3 = 1'b1;
        bus3.tx_data = 8'h96;
        bus3.ch_sel = 2'd3;
        bus3.tx_start = 1'b1;
        @(posedge clk);
        #1;
        bus3.tx_start = 1'b0;
        chk_frame("t5oor", {6'd0, 1'b1, 8'h96, 1'b0}, 10, 100);
        post("t5oor");
        sel3 = 1'b0;

        send(8'hA5, 2'd3, 2'b00, 1'b0, 1'b0);
        repeat (44) @(posedge clk);
        #1;
        chk1("t6_bit3_low", bus.tx, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk1("t6_rst_tx", bus.tx, 1'b1);
        chk1("t6_rst_idle", bus.tx_idle, 1'b1);
        chk1("t6_rst_done", bus.tx_done, 1'b0);
        rst = 1'b1;
        quiet("t6", 120);
        send(8'h3C, 2'd3, 2'b00, 1'b0, 1'b0);
        chk_frame("t6n", {6'd0, 1'b1, 8'h3C, 1'b0}, 10, 10);
        post("t6n");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
